// File: rtl/uart_cmd_pkg.sv
// Shared types and ASCII constants for the UART command decoder.
package uart_cmd_pkg;

  localparam int unsigned CNT_W = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIGITS  = 2'd1,
    WAIT_CR = 2'd2
  } cmd_state_e;

  localparam logic [7:0] ASCII_R_UP = 8'h52;
  localparam logic [7:0] ASCII_R_LO = 8'h72;
  localparam logic [7:0] ASCII_C_UP = 8'h43;
  localparam logic [7:0] ASCII_C_LO = 8'h63;
  localparam logic [7:0] ASCII_M_UP = 8'h4D;
  localparam logic [7:0] ASCII_M_LO = 8'h6D;
  localparam logic [7:0] ASCII_S_UP = 8'h53;
  localparam logic [7:0] ASCII_S_LO = 8'h73;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic is_cmd(input logic [7:0] b, input logic [7:0] up,
                                  input logic [7:0] lo);
    return (b == up) || (b == lo);
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_timer.sv
// Inter-byte timeout counter for multi-byte commands.
module cmd_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // terminal fires in the cycle the count advances onto TIMEOUT_CYC-1, so the
  // registered error pulse lands TIMEOUT_CYC cycles after the last byte
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 2);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: held at zero while idle or on a byte, otherwise increments
  always_comb begin
    cnt_d    = cnt_q;
    terminal = 1'b0;
    if (clear || !enable) begin
      cnt_d = '0;
    end else begin
      cnt_d    = cnt_q + W'(1);
      terminal = (cnt_q == LAST);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII command parser: single-byte R/C/M pulses and "Sdddd\r" value load.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  output logic             o_run_toggle,
  output logic             o_clear,
  output logic             o_mode_toggle,
  output logic             o_load,
  output logic [CNT_W-1:0] o_load_val,
  output logic             o_err
);

  cmd_state_e       state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [2:0]       dcnt_q, dcnt_d;
  logic [CNT_W-1:0] load_val_q, load_val_d;
  logic             run_q, run_d;
  logic             clr_q, clr_d;
  logic             mode_q, mode_d;
  logic             load_q, load_d;
  logic             err_q, err_d;
  logic             tmo_term;

  cmd_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_done),
    .enable  (state_q != IDLE),
    .terminal(tmo_term)
  );

  // Next-state, accumulator and pulse decode; a byte always wins over timeout
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    dcnt_d     = dcnt_q;
    load_val_d = load_val_q;
    run_d      = 1'b0;
    clr_d      = 1'b0;
    mode_d     = 1'b0;
    load_d     = 1'b0;
    err_d      = 1'b0;
    if (rx_done) begin
      case (state_q)
        IDLE: begin
          if (is_cmd(rx_data, ASCII_R_UP, ASCII_R_LO)) begin
            run_d = 1'b1;
          end else if (is_cmd(rx_data, ASCII_C_UP, ASCII_C_LO)) begin
            clr_d = 1'b1;
          end else if (is_cmd(rx_data, ASCII_M_UP, ASCII_M_LO)) begin
            mode_d = 1'b1;
          end else if (is_cmd(rx_data, ASCII_S_UP, ASCII_S_LO)) begin
            acc_d   = '0;
            dcnt_d  = '0;
            state_d = DIGITS;
          end
        end
        DIGITS: begin
          if (is_digit(rx_data)) begin
            // low nibble of '0'..'9' is the digit value itself
            acc_d  = (acc_q << 3) + (acc_q << 1) + CNT_W'(rx_data[3:0]);
            dcnt_d = dcnt_q + 3'd1;
            if (dcnt_q == 3'd3) state_d = WAIT_CR;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        WAIT_CR: begin
          if (rx_data == ASCII_CR) begin
            load_val_d = acc_q;
            load_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_term) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end

  // State, datapath and registered output pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      dcnt_q     <= '0;
      load_val_q <= '0;
      run_q      <= 1'b0;
      clr_q      <= 1'b0;
      mode_q     <= 1'b0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      dcnt_q     <= dcnt_d;
      load_val_q <= load_val_d;
      run_q      <= run_d;
      clr_q      <= clr_d;
      mode_q     <= mode_d;
      load_q     <= load_d;
      err_q      <= err_d;
    end
  end

  assign o_run_toggle  = run_q;
  assign o_clear       = clr_q;
  assign o_mode_toggle = mode_q;
  assign o_load        = load_q;
  assign o_load_val    = load_val_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized scoreboard bench for uart_cmd_decoder with a byte-level reference model.
module tb_uart_cmd_decoder;

  localparam int TO = 50;
  localparam int K_RUN = 0, K_CLR = 1, K_MODE = 2, K_LOAD = 3, K_ERR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        o_run_toggle, o_clear, o_mode_toggle, o_load, o_err;
  logic [13:0] o_load_val;

  uart_cmd_decoder #(.TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .o_run_toggle (o_run_toggle),
    .o_clear      (o_clear),
    .o_mode_toggle(o_mode_toggle),
    .o_load       (o_load),
    .o_load_val   (o_load_val),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int kind; int val; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (command text level) ----------------
  bit          m_in_cmd = 0;     // an 'S' has been seen and the command is open
  logic [7:0]  m_buf[$];         // characters received after the 'S'
  int          m_last = 0;       // cycle of the most recent byte

  function automatic bit up_eq(input logic [7:0] b, input logic [7:0] u);
    return (b == u) || (b == (u | 8'h20));
  endfunction

  task automatic push_exp(input int c, input int k, input int v);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic model(input bit v, input logic [7:0] b, input int n);
    int val;
    if (v) begin
      m_last = n;
      if (!m_in_cmd) begin
        if (up_eq(b, "R"))      push_exp(n + 1, K_RUN, 0);
        else if (up_eq(b, "C")) push_exp(n + 1, K_CLR, 0);
        else if (up_eq(b, "M")) push_exp(n + 1, K_MODE, 0);
        else if (up_eq(b, "S")) begin m_in_cmd = 1; m_buf.delete(); end
      end else if (m_buf.size() < 4) begin
        if (b >= "0" && b <= "9") m_buf.push_back(b);
        else begin push_exp(n + 1, K_ERR, 0); m_in_cmd = 0; end
      end else begin
        if (b == 8'h0D) begin
          val = 0;
          foreach (m_buf[i]) val = val * 10 + int'(m_buf[i]) - 48;
          push_exp(n + 1, K_LOAD, val);
        end else begin
          push_exp(n + 1, K_ERR, 0);
        end
        m_in_cmd = 0;
      end
    end else if (m_in_cmd && (n - m_last) == TO - 1) begin
      push_exp(n + 1, K_ERR, 0);
      m_in_cmd = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit v, input logic [7:0] b);
    @(posedge clk); #1;
    rx_done = v;
    rx_data = v ? b : 8'($urandom);
    model(v, b, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send(input string s, input int gap);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      step(1'b1, c);
      idle(gap);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    step(1'b1, b);
    idle($urandom_range(0, 2));
  endtask

  task automatic rand_digits(input int n);
    for (int i = 0; i < n; i++) send_byte(8'("0") + 8'($urandom_range(0, 9)));
  endtask

  // ---------------- monitor ----------------
  int mon_val = 0;

  function automatic int act_kind();
    if (o_run_toggle)  return K_RUN;
    if (o_clear)       return K_CLR;
    if (o_mode_toggle) return K_MODE;
    if (o_load)        return K_LOAD;
    return K_ERR;
  endfunction

  always @(negedge clk) begin
    int   npulse;
    exp_t e;
    if (rst) begin
      mon_val = 0;
    end else begin
      npulse = int'(o_run_toggle) + int'(o_clear) + int'(o_mode_toggle)
             + int'(o_load) + int'(o_err);
      chk("pulse_exclusive", int'(npulse <= 1), 1);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("missing_pulse_kind", -1, e.kind);
      end
      if (npulse != 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_kind", act_kind(), -1);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", act_kind(), e.kind);
          chk("pulse_cycle", cyc, e.cyc);
          if (e.kind == K_LOAD) begin
            chk("load_val_on_load", int'(o_load_val), e.val);
            mon_val = e.val;
          end
        end
      end
      chk("load_val_hold", int'(o_load_val), mon_val);
    end
  end

  // ---------------- main sequence ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rx_done = 1'b0;
    exp_q.delete(); m_in_cmd = 0;
    idle(2);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int r;
    logic [7:0] b;
    string letters;
    letters = "RrCcMm";

    idle(3);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_run",  int'(o_run_toggle), 0);
    chk("reset_clr",  int'(o_clear), 0);
    chk("reset_mode", int'(o_mode_toggle), 0);
    chk("reset_load", int'(o_load), 0);
    chk("reset_err",  int'(o_err), 0);
    chk("reset_val",  int'(o_load_val), 0);

    // single-byte commands
    send("Rc", 0); send("M", 1);
    // set commands
    send("S1234\r", 0); send("s0007\r", 1); send("S9999\r", 0);
    // malformed
    send("S12A", 0); send("S12345", 0); send("x\n\r", 0);
    // timeout then recovery
    send("S12", 0); idle(60); send("R", 0);
    // byte arriving exactly in the timeout terminal cycle
    send("S12", 0); idle(TO - 2); send("3", 0); idle(TO - 2); send("4\r", 0);
    // byte one cycle late: timeout fires first
    send("S1", 0); idle(TO - 1); send("2", 0);
    // reset mid-command
    send("S56", 0);
    do_reset();
    @(negedge clk);
    chk("val_after_reset", int'(o_load_val), 0);
    send("\r", 0); idle(3);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: begin b = letters[$urandom_range(0, 5)]; send_byte(b); end
        3, 4, 5: begin
          send_byte($urandom_range(0, 1) ? 8'h53 : 8'h73);
          rand_digits(4); send_byte(8'h0D);
        end
        6: begin
          send_byte(8'h53); rand_digits($urandom_range(0, 3));
          send_byte(8'($urandom_range(0, 255)));
        end
        7: begin
          send_byte(8'h73); rand_digits(4);
          send_byte(8'($urandom_range(0, 255)));
        end
        8: send_byte(8'($urandom_range(0, 255)));
        default: begin
          send_byte(8'h53); rand_digits(2);
          idle($urandom_range(TO - 4, TO + 4));
          rand_digits(2); send_byte(8'h0D);
        end
      endcase
    end

    idle(TO + 10);
    chk("leftover_expected", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-level command parser directly downstream of the UART receiver. Consumes each received byte (`rx_data` qualified by the one-cycle `rx_done` pulse) and turns ASCII commands into single-cycle control pulses and a load value for the 0–9999 counter core. Supports single-byte commands and one multi-byte "set value" command, with an error pulse and an inter-byte timeout.

## Interface
- `TIMEOUT_CYC`, default 100_000_000: clk cycles allowed between bytes of a multi-byte command (1 s at 100 MHz).
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high. Clock is `clk`.
- `rx_data` in 8: received byte, valid only while `rx_done`=1.
- `rx_done` in 1: one-cycle byte-valid strobe from the UART receiver.
- `o_run_toggle` out 1: one-cycle pulse; counter run/stop toggle.
- `o_clear` out 1: one-cycle pulse; counter clear.
- `o_mode_toggle` out 1: one-cycle pulse; up/down mode toggle.
- `o_load` out 1: one-cycle pulse; load `o_load_val` into the counter.
- `o_load_val` out 14: decoded value, 0–9999; holds until the next successful load.
- `o_err` out 1: one-cycle pulse; malformed command or timeout.

## Operation
- Case-insensitive commands:
  - `R`/`r` (0x52/0x72) → `o_run_toggle`.
  - `C`/`c` → `o_clear`.
  - `M`/`m` → `o_mode_toggle`.
  - `S`/`s` followed by exactly 4 ASCII digits (0x30–0x39), then CR (0x0D) → `o_load`.
- FSM states: IDLE, DIGITS, WAIT_CR. All transitions are taken only on `rx_done`=1, except timeout.
- **IDLE**
  - `R`/`C`/`M`: pulse the matching output.
  - `S`: clear the accumulator and digit count, then go to DIGITS.
  - Any other byte, including CR and LF: ignored silently, no `o_err`.
- **DIGITS**
  - Digit: `acc <= acc*10 + (byte-0x30)` and `dcnt++`.
  - 4th digit: go to WAIT_CR.
  - Any non-digit, including a new `S`: pulse `o_err`, return to IDLE, discard the byte.
- **WAIT_CR**
  - CR: `o_load_val <= acc`, pulse `o_load`, go to IDLE.
  - Any other byte: pulse `o_err`, go to IDLE.
- **Arithmetic:** 14-bit accumulator. `acc*10` is formed as `(acc<<3)+(acc<<1)`. Max is 999*10+9 = 9999, so there is no overflow. Leading zeros are allowed ("0042" → 42).
- **Timeout:** counter runs only in DIGITS/WAIT_CR and resets to 0 on every `rx_done` and on entry from IDLE. On reaching `TIMEOUT_CYC-1` without a byte: pulse `o_err`, go to IDLE.
- **Simultaneous events:** `rx_done` in the timeout terminal cycle → the byte is processed and the timeout does not fire.
- **Output exclusivity:** at most one of the five pulse outputs is high in any cycle.

## Timing
- **Reset:** all pulses 0, `o_load_val`=0, state IDLE, accumulator, `dcnt` and timeout counter 0.
- **Latency:**
  - All outputs are registered. A pulse is asserted in the cycle after the `rx_done` cycle and lasts exactly 1 cycle.
  - `o_load_val` updates in the same cycle `o_load` rises.
- **Back-to-back bytes:** `rx_done` on consecutive cycles must be accepted. No byte is dropped and there is no backpressure.
- **Reset mid-command:** the partial command is abandoned, no pulse is emitted, and `o_load_val` returns to 0.

## Structure
- Package `uart_cmd_pkg`:
  - State enum `cmd_state_e` (IDLE, DIGITS, WAIT_CR).
  - ASCII constants: `ASCII_R/C/M/S` upper and lower, `ASCII_0`, `ASCII_9`, `ASCII_CR`.
  - Value width `CNT_W`=14.
- Sub-module `cmd_timeout_timer`:
  - Inputs: clear, enable.
  - Output: terminal pulse.
  - Parameterised by `TIMEOUT_CYC`, counter width `$clog2(TIMEOUT_CYC)`.
- Parser FSM and accumulator live in the top module.

## Test plan
1. **Single-byte commands:** bytes 0x52, 0x63, 0x4D → exactly one cycle each of `o_run_toggle`, `o_clear`, `o_mode_toggle`, in order, each 1 cycle after its `rx_done`.
2. **Set command:** "S1234\r" → single `o_load` pulse with `o_load_val`=1234. Then "s0007\r" → 7. Then "S9999\r" → 9999.
3. **Malformed input:**
   - "S12A" → `o_err` after the `A` byte; FSM back in IDLE; `o_load_val` unchanged.
   - "S12345" → `o_err` on `5`.
   - "x\n\r" in IDLE → no output pulses.
4. **Timeout** (`TIMEOUT_CYC`=50): "S12" then 60 idle cycles → `o_err` 50 cycles after the last `rx_done`. A subsequent "R" → `o_run_toggle`.
5. **Timeout collision** (`TIMEOUT_CYC`=50): `rx_done` with "3" exactly in the terminal cycle → no `o_err`. "4\r" afterwards → `o_load_val`=1234.
6. **Reset mid-command:** assert `rst` after "S56", then send "\r" → no `o_load`. Throughout, check `o_load_val`=0 and at most one pulse output high in any cycle.
